// File: rtl/log_reader_if.sv
// Byte stream from log_reader toward the UART TX path.
// Byte moves when valid && ready are high at a rising clock edge.
interface log_reader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/log_reader.sv
// Walks the logger memory and streams each word as bytes, MSB first.
// Define LOG_READER_HEADER_EN to prefix each dump with sync bytes A5 5A.
module log_reader #(
  parameter int RAM_WIDTH    = 32,
  parameter int RAM_DEPTH    = 32767,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic                  i_mem_full,
  input  logic [RAM_WIDTH-1:0]  i_data_log_from_mem,
  output logic                  o_read_log,
  output logic [ADDR_WIDTH-1:0] o_addr_log_to_mem,
  log_reader_if.master          tx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_abort
);

  localparam int NB = RAM_WIDTH / 8;
  localparam int BW = (NB > 2) ? $clog2(NB) : 1;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef LOG_READER_HEADER_EN
    S_HEADER,
`endif
    S_ADDR,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         idx_q;
  logic [RAM_WIDTH-1:0]  shreg_q;
  logic                  start_prev_q;
  logic                  armed_q;
  logic                  pend_q;
  logic                  start_edge;
  logic                  hs;
  logic                  kill;
  logic                  last_byte;
  logic                  last_addr;

  // armed_q keeps a start held high across reset from looking like an edge
  assign start_edge = i_start && !start_prev_q && armed_q;
  assign hs         = tx.valid && tx.ready;
  assign kill       = pend_q || !i_mem_full;
  assign last_byte  = idx_q == BW'(NB - 1);
  assign last_addr  = addr_q == ADDR_WIDTH'(RAM_DEPTH - 1);

  assign o_read_log        = (state_q == S_ADDR) || (state_q == S_WAIT);
  assign o_addr_log_to_mem = addr_q;
  assign o_busy            = state_q != S_IDLE;
  assign o_done            = state_q == S_DONE;

  always_comb begin
    tx.valid = 1'b0;
    tx.data  = 8'h00;
    if (state_q == S_SEND) begin
      tx.valid = 1'b1;
      tx.data  = shreg_q[RAM_WIDTH-1 -: 8];
    end
`ifdef LOG_READER_HEADER_EN
    if (state_q == S_HEADER) begin
      tx.valid = 1'b1;
      tx.data  = (idx_q == '0) ? 8'hA5 : 8'h5A;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    o_abort = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge && i_mem_full) begin
`ifdef LOG_READER_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_ADDR;
`endif
        end
      end
`ifdef LOG_READER_HEADER_EN
      S_HEADER: begin
        if (hs) begin
          if (kill) begin
            o_abort = 1'b1;
            state_d = S_IDLE;
          end else if (idx_q == BW'(1)) begin
            state_d = S_ADDR;
          end
        end
      end
`endif
      S_ADDR: begin
        if (!i_mem_full) begin
          o_abort = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_mem_full) begin
          o_abort = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (hs) begin
          if (kill) begin
            o_abort = 1'b1;
            state_d = S_IDLE;
          end else if (last_byte) begin
            state_d = last_addr ? S_DONE : S_ADDR;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      start_prev_q <= i_start;
      if (!i_start) armed_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (state_d != S_IDLE) begin
            addr_q <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
          end
        end
`ifdef LOG_READER_HEADER_EN
        S_HEADER: begin
          if (!i_mem_full) pend_q <= 1'b1;
          if (hs)          idx_q  <= idx_q + 1'b1;
        end
`endif
        S_ADDR: cnt_q <= CW'(READ_LATENCY - 1);
        S_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            shreg_q <= i_data_log_from_mem;
            idx_q   <= '0;
          end
        end
        S_SEND: begin
          // a drop of full mid-byte is remembered until that byte is taken
          if (!i_mem_full) pend_q <= 1'b1;
          if (hs) begin
            shreg_q <= shreg_q << 8;
            idx_q   <= idx_q + 1'b1;
          end
          if (state_d == S_ADDR) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log_reader.sv
// Bench for log_reader: 4-word log behind a 3-cycle read pipeline.
// Expected streams are built from memory contents with plain arithmetic.
`timescale 1ns/1ps
module tb_log_reader;
  localparam int RW = 32;
  localparam int RD = 4;
  localparam int AW = 15;
  localparam int RL = 3;
  localparam int NB = RW / 8;
`ifdef LOG_READER_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_mem_full = 1'b0;
  logic [RW-1:0] rdata;
  logic          o_read_log;
  logic [AW-1:0] o_addr;
  logic          o_busy, o_done, o_abort;

  log_reader_if tx();

  log_reader #(
    .RAM_WIDTH(RW), .RAM_DEPTH(RD),
    .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_start(i_start),
    .i_mem_full(i_mem_full),
    .i_data_log_from_mem(rdata),
    .o_read_log(o_read_log),
    .o_addr_log_to_mem(o_addr),
    .tx(tx),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory with a three-stage read pipeline
  logic [RW-1:0] mem [RD];
  logic [RW-1:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= mem[o_addr[1:0]];
    p2 <= p1;
    p3 <= p2;
  end
  assign rdata = p3;

  // negedge monitor: values seen here are those at the next rising edge
  int cyc = 0, done_n = 0, abort_n = 0, busy_n = 0;
  int rl_n = 0, valid_n = 0, stab_n = 0, start_cyc = 0;
  logic [7:0] got_q[$];
  int hs_cyc_q[$];
  int addr_q[$];
  logic st_prev = 1'b0, rl_prev = 1'b0, hold = 1'b0;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    st_prev <= i_start;
    rl_prev <= o_read_log;
    if (i_start && !st_prev) start_cyc <= cyc;
    if (tx.valid && tx.ready) begin
      got_q.push_back(tx.data);
      hs_cyc_q.push_back(cyc);
    end
    if (o_read_log && !rl_prev) addr_q.push_back(int'(o_addr));
    done_n  <= done_n + int'(o_done);
    abort_n <= abort_n + int'(o_abort);
    busy_n  <= busy_n + int'(o_busy);
    rl_n    <= rl_n + int'(o_read_log);
    valid_n <= valid_n + int'(tx.valid);
    if (hold && reset_n && (!tx.valid || tx.data !== held))
      stab_n <= stab_n + 1;
    hold <= reset_n && tx.valid && !tx.ready;
    held <= tx.data;
  end

  logic [7:0] exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp;
    exp_q = {};
    if (HDR != 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
    end
    for (int a = 0; a < RD; a++)
      for (int b = NB - 1; b >= 0; b--)
        exp_q.push_back(8'(mem[a] >> (8 * b)));
  endtask

  task automatic load_fixed;
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    mem[2] = 32'h99AABBCC;
    mem[3] = 32'hDDEEFF00;
    build_exp();
  endtask

  function automatic logic rdy(input int mode, input int i);
    case (mode)
      0: return 1'b1;
      1: return (i % 4 == 0) || (i % 4 == 3);
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic pulse_start;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // run one dump to completion; restart=1 pokes start again mid-dump
  task automatic run_dump(input int mode, input bit restart);
    int i;
    i = 0;
    tx.ready = rdy(mode, 0);
    pulse_start();
    while (o_busy && i < 2000) begin
      tx.ready = rdy(mode, i);
      if (restart) i_start = (i >= 10 && i < 12);
      tick();
      i++;
    end
    i_start  = 1'b0;
    tx.ready = 1'b0;
    checks++;
    if (o_busy) begin
      $display("FAIL dump_timeout: busy=%0b after %0d cycles, required 0", o_busy, i);
      errors++;
    end
  endtask

  task automatic test_reset;
    int b0, r0;
    reset_n = 1'b0;
    i_mem_full = 1'b1;
    tx.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_read_log, o_addr, tx.data, tx.valid, o_busy, o_done, o_abort} !== '0) begin
      $display("FAIL reset_outputs: rl=%0b addr=%0d data=%h v=%0b busy=%0b done=%0b abort=%0b, required all 0",
               o_read_log, o_addr, tx.data, tx.valid, o_busy, o_done, o_abort);
      errors++;
    end
    reset_n = 1'b1;
    repeat (2) tick();
    i_start = 1'b1;
    repeat (7) tick();
    checks++;
    if (o_busy !== 1'b1) begin
      $display("FAIL reset_pre_busy: busy=%0b, required 1", o_busy);
      errors++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({o_read_log, o_addr, tx.data, tx.valid, o_busy, o_done, o_abort} !== '0) begin
      $display("FAIL reset_mid_dump: rl=%0b addr=%0d data=%h v=%0b busy=%0b, required all 0",
               o_read_log, o_addr, tx.data, tx.valid, o_busy);
      errors++;
    end
    repeat (2) tick();
    reset_n = 1'b1;
    b0 = busy_n;
    r0 = rl_n;
    repeat (20) tick();
    checks++;
    if (busy_n - b0 != 0 || rl_n - r0 != 0) begin
      $display("FAIL reset_held_start: busy cycles=%0d read cycles=%0d, required 0 0",
               busy_n - b0, rl_n - r0);
      errors++;
    end
    i_start = 1'b0;
    tick();
    run_dump(0, 1'b0);
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== exp_q[exp_q.size()-1]) begin
      $display("FAIL reset_redump: last byte=%h, required %h",
               got_q.size() ? got_q[got_q.size()-1] : 8'h00, exp_q[exp_q.size()-1]);
      errors++;
    end
  endtask

  task automatic test_basic;
    int g0, a0, d0, x0, n;
    g0 = got_q.size();
    a0 = addr_q.size();
    d0 = done_n;
    x0 = abort_n;
    run_dump(0, 1'b0);
    n = got_q.size() - g0;
    checks++;
    if (n != exp_q.size()) begin
      $display("FAIL basic_count: bytes=%0d, required %0d", n, exp_q.size());
      errors++;
    end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (got_q[g0+i] !== exp_q[i]) begin
        $display("FAIL basic_byte%0d: got %h, required %h", i, got_q[g0+i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (addr_q.size() - a0 != RD) begin
      $display("FAIL basic_addr_count: reads=%0d, required %0d", addr_q.size() - a0, RD);
      errors++;
    end else begin
      for (int i = 0; i < RD; i++) begin
        checks++;
        if (addr_q[a0+i] != i) begin
          $display("FAIL basic_addr%0d: got %0d, required %0d", i, addr_q[a0+i], i);
          errors++;
        end
      end
    end
    checks++;
    if (done_n - d0 != 1 || abort_n - x0 != 0) begin
      $display("FAIL basic_pulses: done=%0d abort=%0d, required 1 0", done_n - d0, abort_n - x0);
      errors++;
    end
    checks++;
    if (n == 0 || hs_cyc_q[hs_cyc_q.size()-1] - start_cyc != RD * (1 + RL + NB) + HDR) begin
      $display("FAIL basic_timing: cycles=%0d, required %0d",
               n ? hs_cyc_q[hs_cyc_q.size()-1] - start_cyc : -1, RD * (1 + RL + NB) + HDR);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    int g0, d0, s0, n;
    g0 = got_q.size();
    d0 = done_n;
    s0 = stab_n;
    run_dump(1, 1'b1);
    n = got_q.size() - g0;
    checks++;
    if (n != exp_q.size()) begin
      $display("FAIL bp_count: bytes=%0d, required %0d", n, exp_q.size());
      errors++;
    end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (got_q[g0+i] !== exp_q[i]) begin
        $display("FAIL bp_byte%0d: got %h, required %h", i, got_q[g0+i], exp_q[i]);
        errors++;
      end
    end
    checks++;
    if (stab_n - s0 != 0 || done_n - d0 != 1) begin
      $display("FAIL bp_stable_done: unstable=%0d done=%0d, required 0 1",
               stab_n - s0, done_n - d0);
      errors++;
    end
  endtask

  task automatic test_no_full;
    int b0, r0, v0;
    i_mem_full = 1'b0;
    tx.ready = 1'b1;
    b0 = busy_n;
    r0 = rl_n;
    v0 = valid_n;
    pulse_start();
    repeat (20) tick();
    checks++;
    if (busy_n - b0 != 0 || rl_n - r0 != 0 || valid_n - v0 != 0) begin
      $display("FAIL no_full: busy=%0d read=%0d valid=%0d cycles, required 0 0 0",
               busy_n - b0, rl_n - r0, valid_n - v0);
      errors++;
    end
    i_mem_full = 1'b1;
    tx.ready = 1'b0;
  endtask

  task automatic test_abort_wait;
    int g0, x0, d0, v0, i, n;
    g0 = got_q.size();
    x0 = abort_n;
    d0 = done_n;
    i_mem_full = 1'b1;
    tx.ready = 1'b1;
    pulse_start();
    i = 0;
    while (!(o_read_log && o_addr == AW'(2)) && i < 200) begin
      tick();
      i++;
    end
    checks++;
    if (i >= 200) begin
      $display("FAIL abort_wait_reach: addr 2 not read in %0d cycles, required read", i);
      errors++;
    end
    tick();
    i_mem_full = 1'b0;
    tick();
    v0 = valid_n;
    repeat (5) tick();
    n = got_q.size() - g0;
    checks++;
    if (abort_n - x0 != 1 || done_n - d0 != 0 || o_busy !== 1'b0) begin
      $display("FAIL abort_wait_pulse: abort=%0d done=%0d busy=%0b, required 1 0 0",
               abort_n - x0, done_n - d0, o_busy);
      errors++;
    end
    checks++;
    if (n != 2 * NB + HDR || valid_n - v0 != 0) begin
      $display("FAIL abort_wait_stream: bytes=%0d valid after=%0d, required %0d 0",
               n, valid_n - v0, 2 * NB + HDR);
      errors++;
    end
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      checks++;
      if (got_q[g0+k] !== exp_q[k]) begin
        $display("FAIL abort_wait_byte%0d: got %h, required %h", k, got_q[g0+k], exp_q[k]);
        errors++;
      end
    end
    i_mem_full = 1'b1;
    tx.ready = 1'b0;
  endtask

  task automatic test_abort_send;
    int g0, x0, i;
    g0 = got_q.size();
    x0 = abort_n;
    i_mem_full = 1'b1;
    tx.ready = 1'b0;
    pulse_start();
    i = 0;
    while (!tx.valid && i < 50) begin
      tick();
      i++;
    end
    i_mem_full = 1'b0;
    repeat (4) tick();
    checks++;
    if (tx.valid !== 1'b1 || tx.data !== exp_q[0] || abort_n - x0 != 0) begin
      $display("FAIL abort_send_hold: valid=%0b data=%h abort=%0d, required 1 %h 0",
               tx.valid, tx.data, abort_n - x0, exp_q[0]);
      errors++;
    end
    tx.ready = 1'b1;
    tick();
    tx.ready = 1'b0;
    tick();
    checks++;
    if (abort_n - x0 != 1 || o_busy !== 1'b0 || got_q.size() - g0 != 1) begin
      $display("FAIL abort_send_done: abort=%0d busy=%0b bytes=%0d, required 1 0 1",
               abort_n - x0, o_busy, got_q.size() - g0);
      errors++;
    end else begin
      checks++;
      if (got_q[g0] !== exp_q[0]) begin
        $display("FAIL abort_send_byte: got %h, required %h", got_q[g0], exp_q[0]);
        errors++;
      end
    end
    i_mem_full = 1'b1;
  endtask

  task automatic test_random;
    int g0, d0, s0, n;
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < RD; a++) mem[a] = $urandom;
      build_exp();
      g0 = got_q.size();
      d0 = done_n;
      s0 = stab_n;
      run_dump(2, 1'b0);
      n = got_q.size() - g0;
      checks++;
      if (n != exp_q.size() || done_n - d0 != 1 || stab_n - s0 != 0) begin
        $display("FAIL rand%0d_summary: bytes=%0d done=%0d unstable=%0d, required %0d 1 0",
                 r, n, done_n - d0, stab_n - s0, exp_q.size());
        errors++;
      end
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
        checks++;
        if (got_q[g0+i] !== exp_q[i]) begin
          $display("FAIL rand%0d_byte%0d: got %h, required %h", r, i, got_q[g0+i], exp_q[i]);
          errors++;
        end
      end
    end
  endtask

  initial begin
    tx.ready = 1'b0;
    load_fixed();
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort_wait();
    test_abort_send();
    test_no_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
